movegen_sequencer: RTL and testbench

- Controller for the 64-cell transceiver move-generation array.
- Per search node it runs three phases: loads the board into the cells, clocks move tokens through the array for a fixed number of propagation cycles, then scans every square and streams each arrived move out over a valid/ready interface.
- Sits between the search engine (start/done, move stream) and the cell array plus board memory.

---
 rtl/movegen_pkg.sv | 44 ++++
 rtl/movegen_sequencer_dir_pick.sv | 19 +
 rtl/movegen_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_movegen_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/movegen_pkg.sv
// Shared types and constants for the move-generation sequencer.
package movegen_pkg;

  // Sequencer phases for one search node.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PROP,
    ST_SCAN_ADDR,
    ST_SCAN_WAIT,
    ST_EMIT,
    ST_FINISH
  } state_e;

  // Arrival direction codes; the value equals the scan_hit bit index.
  typedef enum logic [3:0] {
    DIR_U   = 4'd0,
    DIR_D   = 4'd1,
    DIR_L   = 4'd2,
    DIR_R   = 4'd3,
    DIR_UL  = 4'd4,
    DIR_UR  = 4'd5,
    DIR_DL  = 4'd6,
    DIR_DR  = 4'd7,
    DIR_UUL = 4'd8,
    DIR_UUR = 4'd9,
    DIR_LLU = 4'd10,
    DIR_RRU = 4'd11,
    DIR_DDL = 4'd12,
    DIR_DDR = 4'd13,
    DIR_LLD = 4'd14,
    DIR_RRD = 4'd15
  } dir_e;

  localparam logic WHITE = 1'b1;
  localparam logic BLACK = 1'b0;

  // Piece code that represents an empty cell; also the idle value of the load bus.
  localparam logic [5:0] EMPTY_PIECE_REG = 6'd0;

  // Last square on the board; the scan ends after it.
  localparam logic [5:0] LAST_SQ = 6'd63;

endpackage

// File: rtl/movegen_sequencer_dir_pick.sv
// Lowest-set-bit priority encoder over the 16 direction hit flags.
module dir_pick
  import movegen_pkg::*;
(
  input  logic [15:0] mask_i,
  output dir_e        dir_o,
  output logic        any_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    dir_o = DIR_U;
    any_o = |mask_i;
    for (int i = 15; i >= 0; i--) begin
      if (mask_i[i]) dir_o = dir_e'(i);
    end
  end

endmodule

// File: rtl/movegen_sequencer.sv
// Per-node controller for the 64-cell move-generation array:
// load the board, propagate move tokens, then scan and stream moves out.
module movegen_sequencer
  import movegen_pkg::*;
#(
  parameter int PROP_CYCLES   = 8,
  parameter int PAWN_PASS_CYC = 1,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             side_to_move,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] move_count,
  output logic [5:0]       board_rd_addr,
  input  logic [5:0]       board_rd_data,
  output logic             cell_load_en,
  output logic [5:0]       cell_load_addr,
  output logic [5:0]       cell_load_piece,
  output logic             engine_color,
  output logic             array_run,
  output logic             pawn_pass,
  output logic [5:0]       scan_addr,
  input  logic [15:0]      scan_hit,
  output logic             move_valid,
  input  logic             move_ready,
  output logic [5:0]       move_to,
  output logic [3:0]       move_dir
);

  // Move stream handshake: a move transfers on every rising edge where
  // move_valid and move_ready are both high. Once move_valid is raised,
  // move_to/move_dir hold until that transfer (or an abort withdraws it);
  // move_ready may toggle freely and is not required before valid.

  state_e           state_q, state_d;
  logic [6:0]       cnt_q, cnt_d;      // load index (0..64) or propagation cycle
  logic [5:0]       sq_q, sq_d;        // square being scanned
  logic [15:0]      mask_q, mask_d;    // directions still to emit for sq_q
  logic [CNT_W-1:0] count_q, count_d;
  logic             color_q, color_d;
  logic             advance;           // current square finished, move to next
  dir_e             pick_dir;
  logic             pick_any;

  dir_pick u_dir_pick (
    .mask_i (mask_q),
    .dir_o  (pick_dir),
    .any_o  (pick_any)
  );

  assign move_count   = count_q;
  assign engine_color = color_q;

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sq_q    <= '0;
      mask_q  <= '0;
      count_q <= '0;
      color_q <= BLACK;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sq_q    <= sq_d;
      mask_q  <= mask_d;
      count_q <= count_d;
      color_q <= color_d;
    end
  end

  // Next-state and output decode; abort overrides everything at the end.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    sq_d            = sq_q;
    mask_d          = mask_q;
    count_d         = count_q;
    color_d         = color_q;
    advance         = 1'b0;
    busy            = (state_q != ST_IDLE);
    done            = 1'b0;
    board_rd_addr   = '0;
    cell_load_en    = 1'b0;
    cell_load_addr  = '0;
    cell_load_piece = EMPTY_PIECE_REG;
    array_run       = 1'b0;
    pawn_pass       = 1'b0;
    scan_addr       = '0;
    move_valid      = 1'b0;
    move_to         = '0;
    move_dir        = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          color_d = side_to_move ? WHITE : BLACK;
          count_d = '0;
          cnt_d   = '0;
          state_d = ST_LOAD;
        end
      end

      // Read address leads the cell write by one cycle (memory latency).
      ST_LOAD: begin
        if (!cnt_q[6]) board_rd_addr = cnt_q[5:0];
        if (cnt_q != 7'd0) begin
          cell_load_en    = 1'b1;
          cell_load_addr  = cnt_q[5:0] - 6'd1;
          cell_load_piece = board_rd_data;
        end
        if (cnt_q == 7'd64) begin
          cnt_d   = '0;
          state_d = ST_PROP;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end

      ST_PROP: begin
        array_run = 1'b1;
        pawn_pass = (cnt_q == 7'(PAWN_PASS_CYC));
        if (cnt_q == 7'(PROP_CYCLES - 1)) begin
          cnt_d   = '0;
          sq_d    = '0;
          state_d = ST_SCAN_ADDR;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end

      ST_SCAN_ADDR: begin
        scan_addr = sq_q;
        state_d   = ST_SCAN_WAIT;
      end

      ST_SCAN_WAIT: begin
        scan_addr = sq_q;
        mask_d    = scan_hit;
        if (scan_hit == 16'h0) advance = 1'b1;
        else                   state_d = ST_EMIT;
      end

      ST_EMIT: begin
        scan_addr  = sq_q;
        move_valid = pick_any;
        move_to    = sq_q;
        move_dir   = pick_dir;
        if (!pick_any) begin
          advance = 1'b1;
        end else if (move_ready) begin
          mask_d = mask_q & ~(16'h0001 << pick_dir);
          if (count_q != {CNT_W{1'b1}}) count_d = count_q + 1'b1;
          if (mask_d == 16'h0) advance = 1'b1;
        end
      end

      ST_FINISH: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    if (advance) begin
      if (sq_q == LAST_SQ) begin
        state_d = ST_FINISH;
      end else begin
        sq_d    = sq_q + 6'd1;
        state_d = ST_SCAN_ADDR;
      end
    end

    // Abort withdraws every strobe this cycle and freezes the counters.
    if (abort && state_q != ST_IDLE) begin
      state_d         = ST_IDLE;
      cnt_d           = cnt_q;
      sq_d            = sq_q;
      mask_d          = mask_q;
      count_d         = count_q;
      done            = 1'b0;
      board_rd_addr   = '0;
      cell_load_en    = 1'b0;
      cell_load_addr  = '0;
      cell_load_piece = EMPTY_PIECE_REG;
      array_run       = 1'b0;
      pawn_pass       = 1'b0;
      scan_addr       = '0;
      move_valid      = 1'b0;
      move_to         = '0;
      move_dir        = '0;
    end
  end

endmodule

// File: tb/tb_movegen_sequencer.sv
// Self-checking bench for movegen_sequencer: scenario table, hand-written
// corner sequences and randomized runs against a list-based reference model.
module tb_movegen_sequencer;

  localparam int PROP_CYCLES   = 8;
  localparam int PAWN_PASS_CYC = 1;
  localparam int CNT_W         = 8;
  localparam int SAT           = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             side_to_move = 1'b0;
  logic             busy, done;
  logic [CNT_W-1:0] move_count;
  logic [5:0]       board_rd_addr;
  logic [5:0]       board_rd_data = 6'd0;
  logic             cell_load_en;
  logic [5:0]       cell_load_addr, cell_load_piece;
  logic             engine_color, array_run, pawn_pass;
  logic [5:0]       scan_addr;
  logic [15:0]      scan_hit = 16'h0;
  logic             move_valid;
  logic             move_ready = 1'b0;
  logic [5:0]       move_to;
  logic [3:0]       move_dir;

  movegen_sequencer #(
    .PROP_CYCLES   (PROP_CYCLES),
    .PAWN_PASS_CYC (PAWN_PASS_CYC),
    .CNT_W         (CNT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .abort           (abort),
    .side_to_move    (side_to_move),
    .busy            (busy),
    .done            (done),
    .move_count      (move_count),
    .board_rd_addr   (board_rd_addr),
    .board_rd_data   (board_rd_data),
    .cell_load_en    (cell_load_en),
    .cell_load_addr  (cell_load_addr),
    .cell_load_piece (cell_load_piece),
    .engine_color    (engine_color),
    .array_run       (array_run),
    .pawn_pass       (pawn_pass),
    .scan_addr       (scan_addr),
    .scan_hit        (scan_hit),
    .move_valid      (move_valid),
    .move_ready      (move_ready),
    .move_to         (move_to),
    .move_dir        (move_dir)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- environment: board memory and cell array ----------------
  logic [5:0]  board_mem [64];
  logic [15:0] hit_mem   [64];

  always @(posedge clk) begin
    board_rd_data <= board_mem[board_rd_addr];
    scan_hit      <= hit_mem[scan_addr];
  end

  bit ready_rand = 1'b0;
  always @(posedge clk) begin
    #2;
    if (ready_rand) move_ready = ($urandom_range(0, 3) != 0);
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard ----------------
  int vectors = 0;
  int miscompares = 0;

  logic [11:0] exp_ld_q[$];   // {addr, piece}
  logic [9:0]  exp_q[$];      // {to, dir}
  int          n_model;
  int          exp_cnt;

  bit mon_en = 1'b0;
  int xfer_cnt, done_cnt, prop_cnt, pawn_cnt;
  int first_xfer_cyc, last_xfer_cyc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: every load write in address order, and every hit as
  // a move in square-major, direction-minor order.
  task automatic build_model();
    exp_ld_q.delete();
    exp_q.delete();
    for (int a = 0; a < 64; a++) exp_ld_q.push_back({6'(a), board_mem[a]});
    for (int s = 0; s < 64; s++)
      for (int d = 0; d < 16; d++)
        if (hit_mem[s][d]) exp_q.push_back({6'(s), 4'(d)});
    n_model = exp_q.size();
    exp_cnt = (n_model > SAT) ? SAT : n_model;
    xfer_cnt = 0; done_cnt = 0; prop_cnt = 0; pawn_cnt = 0;
    first_xfer_cyc = 0; last_xfer_cyc = 0;
  endtask

  // Monitor: checks every load write and every transferred move in order.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (cell_load_en) begin
        if (exp_ld_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL load_extra: got write addr %0d expected none", cell_load_addr);
        end else begin
          check("load_write", {cell_load_addr, cell_load_piece}, exp_ld_q.pop_front());
        end
      end
      if (pawn_pass) begin
        check("pawn_idx", prop_cnt, PAWN_PASS_CYC);
        pawn_cnt++;
      end
      if (array_run) prop_cnt++;
      if (move_valid && move_ready) begin
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL move_extra: got to=%0d dir=%0d expected none", move_to, move_dir);
        end else begin
          check("move", {move_to, move_dir}, exp_q.pop_front());
        end
        if (xfer_cnt == 0) first_xfer_cyc = cyc;
        last_xfer_cyc = cyc;
        xfer_cnt++;
      end
      if (done) done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic fill_board(input bit empty);
    for (int s = 0; s < 64; s++) board_mem[s] = empty ? 6'd0 : 6'($urandom_range(0, 63));
  endtask

  task automatic start_run(input bit side);
    build_model();
    side_to_move = side;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 6000 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, seen, 1);
    @(negedge clk);
  endtask

  task automatic end_checks(input string tag, input bit side);
    check({tag, "_busy_idle"},  busy, 0);
    check({tag, "_done_once"},  done_cnt, 1);
    check({tag, "_prop_cyc"},   prop_cnt, PROP_CYCLES);
    check({tag, "_pawn_once"},  pawn_cnt, 1);
    check({tag, "_loads_left"}, exp_ld_q.size(), 0);
    check({tag, "_moves_left"}, exp_q.size(), 0);
    check({tag, "_xfers"},      xfer_cnt, n_model);
    check({tag, "_count"},      move_count, exp_cnt);
    check({tag, "_color"},      engine_color, side);
  endtask

  // ---------------- scenario table ----------------
  typedef struct {
    int          sq;
    logic [15:0] hit;
    bit          all_sq;
    int          exp_xfers;
    int          exp_count;
  } vec_t;

  vec_t vt[5];

  initial begin
    bit seen;
    bit side;

    vt[0] = '{sq: 0,  hit: 16'h0000, all_sq: 1'b0, exp_xfers: 0,    exp_count: 0};
    vt[1] = '{sq: 12, hit: 16'h0101, all_sq: 1'b0, exp_xfers: 2,    exp_count: 2};
    vt[2] = '{sq: 0,  hit: 16'h8000, all_sq: 1'b0, exp_xfers: 1,    exp_count: 1};
    vt[3] = '{sq: 63, hit: 16'h0003, all_sq: 1'b0, exp_xfers: 2,    exp_count: 2};
    vt[4] = '{sq: 0,  hit: 16'hFFFF, all_sq: 1'b1, exp_xfers: 1024, exp_count: 255};

    fill_board(1'b1);
    for (int s = 0; s < 64; s++) hit_mem[s] = 16'h0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_outs", {busy, done, move_count, board_rd_addr, cell_load_en, cell_load_addr,
                         cell_load_piece, engine_color, array_run, pawn_pass, scan_addr,
                         move_valid, move_to, move_dir}, 64'h0);
    tick();
    rst = 1'b0;
    tick();

    // Reset in the middle of LOAD, at load cycle 30.
    side_to_move = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("midload_addr", board_rd_addr, 30);
    check("midload_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("midload_reset_outs", {busy, done, move_count, board_rd_addr, cell_load_en, cell_load_addr,
                                 cell_load_piece, engine_color, array_run, pawn_pass, scan_addr,
                                 move_valid, move_to, move_dir}, 64'h0);
    tick();
    rst = 1'b0;
    tick();
    mon_en = 1'b1;

    // Table-driven full runs with ready held high.
    ready_rand = 1'b0;
    move_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      fill_board(i == 0);
      for (int s = 0; s < 64; s++) hit_mem[s] = (vt[i].all_sq || s == vt[i].sq) ? vt[i].hit : 16'h0;
      side = 1'($urandom_range(0, 1));
      start_run(side);
      wait_done($sformatf("tab%0d", i));
      end_checks($sformatf("tab%0d", i), side);
      check($sformatf("tab%0d_tbl_xfers", i), xfer_cnt, vt[i].exp_xfers);
      check($sformatf("tab%0d_tbl_count", i), move_count, vt[i].exp_count);
      if (!vt[i].all_sq && vt[i].exp_xfers > 1)
        check($sformatf("tab%0d_back_to_back", i), last_xfer_cyc - first_xfer_cyc, vt[i].exp_xfers - 1);
    end

    // Ready held low on the first offer: the offer must stay put.
    fill_board(1'b0);
    for (int s = 0; s < 64; s++) hit_mem[s] = (s == 12) ? 16'h0101 : 16'h0;
    move_ready = 1'b0;
    start_run(1'b0);
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      if (move_valid) seen = 1'b1;
    end
    check("stall_offer_seen", seen, 1);
    check("stall_offer", {move_to, move_dir}, {6'd12, 4'd0});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_hold", {move_valid, move_to, move_dir}, {1'b1, 6'd12, 4'd0});
    end
    tick();
    move_ready = 1'b1;
    wait_done("stall");
    end_checks("stall", 1'b0);

    // Abort during EMIT while a move is offered and ready is low.
    for (int s = 0; s < 64; s++) hit_mem[s] = (s == 12) ? 16'h0003 : 16'h0;
    move_ready = 1'b1;
    start_run(1'b1);
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      if (move_valid && move_ready) seen = 1'b1;
    end
    check("ab_first_offer", seen, 1);
    tick();
    move_ready = 1'b0;
    @(negedge clk);
    check("ab_second_offer", {move_valid, move_to, move_dir}, {1'b1, 6'd12, 4'd1});
    tick();
    abort = 1'b1;
    @(negedge clk);
    check("ab_valid_drop", move_valid, 0);
    tick();
    abort = 1'b0;
    @(negedge clk);
    check("ab_idle", busy, 0);
    check("ab_count_kept", move_count, 1);
    check("ab_no_done", done_cnt, 0);
    check("ab_xfers", xfer_cnt, 1);

    // start and abort together in IDLE: abort wins, count untouched.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check("sa_stay_idle", busy, 0);
    check("sa_count_kept", move_count, 1);
    repeat (3) @(negedge clk);
    check("sa_still_idle", busy, 0);

    // Randomized runs: sparse random hits, random backpressure.
    ready_rand = 1'b1;
    for (int r = 0; r < 6; r++) begin
      fill_board(1'b0);
      for (int s = 0; s < 64; s++)
        hit_mem[s] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0;
      side = 1'($urandom_range(0, 1));
      start_run(side);
      wait_done($sformatf("rnd%0d", r));
      end_checks($sformatf("rnd%0d", r), side);
    end
    ready_rand = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
